// File: rtl/countdown_mm_ss.sv
// countdown_mm_ss: MM:SS down-counter with IDLE/RUN/PAUSE/DONE control FSM.
// Both fields count modulo MOD. A seconds wrap produces a one-cycle borrow
// strobe z. Reaching 00:00 produces a one-cycle done strobe.
// Control inputs are plain levels sampled on every rising edge; there is no
// valid/ready handshake. Within one cycle, priority is load > stop > start > tick.
module countdown_mm_ss #(
   parameter int MOD = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [6:0] ld_min,
   input  logic [6:0] ld_sec,
   input  logic       start,
   input  logic       stop,
   output logic [6:0] min_out,
   output logic [6:0] sec_out,
   output logic       running,
   output logic       z,
   output logic       done,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [6:0] C_MAX = 7'(MOD - 1);

   state_t     r_state;
   logic [6:0] r_min;
   logic [6:0] r_sec;
   logic       r_z;
   logic       r_done;

   state_t     w_state_nxt;
   logic [6:0] w_min_nxt;
   logic [6:0] w_sec_nxt;
   logic       w_z_nxt;
   logic       w_done_nxt;
   logic       w_zero;

   assign w_zero = (r_min == 7'd0) && (r_sec == 7'd0);

   // Next-state, counter and strobe computation; everything holds by default.
   always_comb begin
      w_state_nxt = r_state;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;
      w_z_nxt     = 1'b0;
      w_done_nxt  = 1'b0;
      if (load) begin
         // Load values above the field maximum saturate at MOD-1.
         w_min_nxt   = (ld_min > C_MAX) ? C_MAX : ld_min;
         w_sec_nxt   = (ld_sec > C_MAX) ? C_MAX : ld_sec;
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_PAUSE: begin
               // A start request is ignored when the count is already 00:00.
               if (start && !w_zero) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (stop) begin
                  w_state_nxt = S_PAUSE;
               end else if (tick) begin
                  if (r_sec != 7'd0) begin
                     w_sec_nxt = r_sec - 7'd1;
                     // A wrap never lands on 00:00, so only this branch can finish.
                     if ((r_sec == 7'd1) && (r_min == 7'd0)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                     end
                  end else if (r_min != 7'd0) begin
                     w_sec_nxt = C_MAX;
                     w_min_nxt = r_min - 7'd1;
                     w_z_nxt   = 1'b1;
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State, counter and strobe registers; reset discards any pending strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_min   <= 7'd0;
         r_sec   <= 7'd0;
         r_z     <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_min   <= w_min_nxt;
         r_sec   <= w_sec_nxt;
         r_z     <= w_z_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign min_out   = r_min;
   assign sec_out   = r_sec;
   assign running   = (r_state == S_RUN);
   assign z         = r_z;
   assign done      = r_done;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_countdown_mm_ss.sv
// Bench for countdown_mm_ss: directed scenarios plus random traffic, all checked
// against a total-seconds reference model through an expected-value queue.
module tb_countdown_mm_ss;

   localparam int MOD = 60;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       load;
   logic [6:0] ld_min;
   logic [6:0] ld_sec;
   logic       start;
   logic       stop;
   logic [6:0] min_out;
   logic [6:0] sec_out;
   logic       running;
   logic       z;
   logic       done;
   logic [1:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_min;
   int m_sec;
   int m_mode;
   int m_z;
   int m_done;

   // Expected output vector: {min[6:0], sec[6:0], running, z, done}.
   logic [16:0] exp_q[$];

   countdown_mm_ss #(.MOD(MOD)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .load      (load),
      .ld_min    (ld_min),
      .ld_sec    (ld_sec),
      .start     (start),
      .stop      (stop),
      .min_out   (min_out),
      .sec_out   (sec_out),
      .running   (running),
      .z         (z),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_min  = 0;
      m_sec  = 0;
      m_mode = M_IDLE;
      m_z    = 0;
      m_done = 0;
   endtask

   // Model of one rising edge, computed on total seconds.
   task automatic model_edge();
      int total;
      m_z    = 0;
      m_done = 0;
      total  = m_min * MOD + m_sec;
      if (load) begin
         m_min  = (int'(ld_min) > MOD - 1) ? MOD - 1 : int'(ld_min);
         m_sec  = (int'(ld_sec) > MOD - 1) ? MOD - 1 : int'(ld_sec);
         m_mode = M_IDLE;
      end else if (m_mode == M_RUN && stop) begin
         m_mode = M_PAUSE;
      end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && start) begin
         if (total > 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN && tick && total > 0) begin
         if (m_sec == 0) m_z = 1;
         total = total - 1;
         m_min = total / MOD;
         m_sec = total % MOD;
         if (total == 0) begin
            m_mode = M_DONE;
            m_done = 1;
         end
      end
      exp_q.push_back({7'(m_min), 7'(m_sec), (m_mode == M_RUN), m_z[0], m_done[0]});
   endtask

   task automatic check_outputs();
      logic [16:0] e;
      if (exp_q.size() == 0) begin
         chk("exp_q_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("min_out", 32'(min_out), 32'(e[16:10]));
         chk("sec_out", 32'(sec_out), 32'(e[9:3]));
         chk("running", 32'(running), 32'(e[2]));
         chk("z",       32'(z),       32'(e[1]));
         chk("done",    32'(done),    32'(e[0]));
      end
   endtask

   // Driver: apply one cycle of inputs, advance the model, check after the edge.
   task automatic step(input logic ld, input logic [6:0] lm, input logic [6:0] ls,
                       input logic st, input logic sp, input logic tk);
      load   = ld;
      ld_min = lm;
      ld_sec = ls;
      start  = st;
      stop   = sp;
      tick   = tk;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      ld_min = 7'd0; ld_sec = 7'd0;
      model_reset();

      // Reset state while rst is held low
      repeat (3) @(posedge clk);
      #1;
      chk("rst_min", 32'(min_out), 32'd0);
      chk("rst_sec", 32'(sec_out), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // After reset: ticks and start at 00:00 do nothing
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b1);
      chk("post_rst_running", 32'(running), 32'd0);

      // 01:00 -> start -> tick gives 00:59 with a one-cycle z
      step(1'b1, 7'd1, 7'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      chk("wrap_sec", 32'(sec_out), 32'd59);
      chk("wrap_z", 32'(z), 32'd1);
      idle_cycles(1);
      chk("wrap_z_clear", 32'(z), 32'd0);

      // 00:02 -> two ticks -> DONE; ticks and start afterwards are ignored
      step(1'b1, 7'd0, 7'd2, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      chk("done_strobe", 32'(done), 32'd1);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b1);
      chk("done_once", 32'(done), 32'd0);

      // Load saturates at MOD-1; ticks in IDLE hold the count
      step(1'b1, 7'd75, 7'd99, 1'b0, 1'b0, 1'b0);
      chk("clamp_min", 32'(min_out), 32'd59);
      chk("clamp_sec", 32'(sec_out), 32'd59);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);

      // 00:10 in RUN: stop+tick -> PAUSE held; start; tick -> 00:09
      step(1'b1, 7'd0, 7'd10, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
      chk("resume_sec", 32'(sec_out), 32'd9);

      // 05:30 in RUN: load 02:00 with start and stop also high -> IDLE
      step(1'b1, 7'd5, 7'd30, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 7'd2, 7'd0, 1'b1, 1'b1, 1'b1);
      chk("load_prio_min", 32'(min_out), 32'd2);
      chk("load_prio_running", 32'(running), 32'd0);

      // Asynchronous reset mid-RUN at 03:17, between clock edges
      step(1'b1, 7'd3, 7'd17, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_min", 32'(min_out), 32'd0);
      chk("arst_sec", 32'(sec_out), 32'd0);
      chk("arst_running", 32'(running), 32'd0);
      chk("arst_z", 32'(z), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(2);

      // Randomized traffic; small loads so DONE and wraps occur often
      for (int i = 0; i < 800; i++) begin
         logic       r_ld;
         logic [6:0] r_lm;
         logic [6:0] r_ls;
         r_ld = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            r_lm = 7'($urandom_range(0, 127));
            r_ls = 7'($urandom_range(0, 127));
         end else begin
            r_lm = 7'($urandom_range(0, 1));
            r_ls = 7'($urandom_range(0, 5));
         end
         step(r_ld, r_lm, r_ls,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
